// File: rtl/ehl_timer_deadtime.sv
// Dead-time inserter: splits each PWM channel into a complementary high/low pair
// with a programmable number of all-off clocks around every edge.
module ehl_timer_deadtime #(
   parameter int   NCH      = 1,
   parameter int   DT_WIDTH = 8,
   parameter logic OUT_POL  = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ena,
   input  logic [DT_WIDTH-1:0] dt_rise,
   input  logic [DT_WIDTH-1:0] dt_fall,
   input  logic [NCH-1:0]      pwm_in,
   output logic [NCH-1:0]      pwm_hi,
   output logic [NCH-1:0]      pwm_lo,
   output logic [NCH-1:0]      dt_busy
);

   typedef enum logic [2:0] {
      S_OFF   = 3'd0,
      S_LO    = 3'd1,
      S_DT_LH = 3'd2,
      S_HI    = 3'd3,
      S_DT_HL = 3'd4
   } state_t;

   localparam logic [DT_WIDTH-1:0] DT_ZERO = '0;
   localparam logic [DT_WIDTH-1:0] DT_ONE  = DT_WIDTH'(1);

   logic [NCH-1:0] pwm_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         pwm_q <= '0;
      end else begin
         pwm_q <= pwm_in;
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      state_t              state;
      state_t              state_nxt;
      logic [DT_WIDTH-1:0] cnt;
      logic [DT_WIDTH-1:0] cnt_nxt;
      logic                hi_r;
      logic                lo_r;
      logic                busy_r;

      always_comb begin
         state_nxt = state;
         cnt_nxt   = cnt;
         if (!ena) begin
            state_nxt = S_OFF;
            cnt_nxt   = DT_ZERO;
         end else begin
            case (state)
               S_OFF, S_LO: begin
                  if (pwm_q[i]) begin
                     if (dt_rise == DT_ZERO) begin
                        state_nxt = S_HI;
                     end else begin
                        state_nxt = S_DT_LH;
                        cnt_nxt   = dt_rise - DT_ONE;
                     end
                  end else begin
                     state_nxt = S_LO;
                  end
               end
               // A pulse that ends before the gap expires is swallowed here.
               S_DT_LH: begin
                  if (!pwm_q[i]) begin
                     state_nxt = S_LO;
                     cnt_nxt   = DT_ZERO;
                  end else if (cnt == DT_ZERO) begin
                     state_nxt = S_HI;
                  end else begin
                     cnt_nxt = cnt - DT_ONE;
                  end
               end
               S_HI: begin
                  if (!pwm_q[i]) begin
                     if (dt_fall == DT_ZERO) begin
                        state_nxt = S_LO;
                     end else begin
                        state_nxt = S_DT_HL;
                        cnt_nxt   = dt_fall - DT_ONE;
                     end
                  end
               end
               S_DT_HL: begin
                  if (pwm_q[i]) begin
                     state_nxt = S_HI;
                     cnt_nxt   = DT_ZERO;
                  end else if (cnt == DT_ZERO) begin
                     state_nxt = S_LO;
                  end else begin
                     cnt_nxt = cnt - DT_ONE;
                  end
               end
               default: begin
                  state_nxt = S_OFF;
                  cnt_nxt   = DT_ZERO;
               end
            endcase
         end
      end

      // Outputs are registered from the next state so they change on the same edge as the FSM.
      always_ff @(posedge clk) begin
         if (reset) begin
            state  <= S_OFF;
            cnt    <= DT_ZERO;
            hi_r   <= ~OUT_POL;
            lo_r   <= ~OUT_POL;
            busy_r <= 1'b0;
         end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            hi_r   <= (state_nxt == S_HI) ? OUT_POL : ~OUT_POL;
            lo_r   <= (state_nxt == S_LO) ? OUT_POL : ~OUT_POL;
            busy_r <= (state_nxt == S_DT_LH) || (state_nxt == S_DT_HL);
         end
      end

      assign pwm_hi[i]  = hi_r;
      assign pwm_lo[i]  = lo_r;
      assign dt_busy[i] = busy_r;
   end

endmodule
